imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Write-side counterpart to the CPU's instruction fetch. It receives a byte stream,
//   packs it into 32-bit little-endian instructions and writes them into instruction
//   memory word by word. It holds the CPU in reset until loading completes. It sits
//   between a host byte source and the imem write port, and drives cpu.reset.
// PARAMETERS
//   DEPTH   32  instruction memory depth in words (matches the 32-word imem)
//   ADDR_W  5   word address width; must equal $clog2(DEPTH)
// PORTS
//   clk           in   1         rising-edge clock
//   reset_n       in   1         asynchronous, active-low reset
//   start         in   1         one-cycle pulse: begin a load session
//   in_valid      in   1         byte-stream valid
//   in_data       in   8         byte-stream data
//   in_ready      out  1         loader accepts a byte when in_valid & in_ready
//   mem_we        out  1         imem write enable (one-cycle pulse per word)
//   mem_addr      out  ADDR_W    imem word address (byte address = mem_addr*4)
//   mem_wdata     out  32        imem write data
//   cpu_reset     out  1         active-high reset to the CPU core
//   busy          out  1         load session in progress
//   done          out  1         sticky: last session completed successfully
//   error         out  1         sticky: last session aborted
//   words_loaded  out  ADDR_W+1  words written in the current/last session
// BEHAVIOUR
//   Reset values (async on reset_n low):
//     in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, busy=0, done=0,
//     error=0, words_loaded=0.
//   Frame format, all fields LE 32-bit words:
//     header N (word count), then N payload words [, checksum word].
//   Byte packing: byte_cnt 0..3; byte k fills bits [8k+7:8k]; word complete on byte 3.
//   Handshake: a byte transfers only when in_valid & in_ready. Gaps in in_valid are
//     legal and hold all state. in_ready=1 only in HDR/DATA/CHK.
//   FSM states: IDLE, HDR, DATA, CHK, DONE, ERR.
//     IDLE/DONE/ERR --start--> HDR: clears done, error, words_loaded and byte_cnt;
//       asserts cpu_reset and busy.
//     start seen in HDR/DATA/CHK is ignored.
//     HDR, word complete: N==0 -> DONE; N>DEPTH -> ERR; else latch N -> DATA.
//     DATA, word complete: next cycle mem_we=1, mem_addr=words_loaded[ADDR_W-1:0],
//       mem_wdata=word (write latency 1 cycle after the 4th byte); words_loaded++.
//       After the Nth word -> DONE (-> CHK when checksum is enabled).
//     DONE: done=1, busy=0, cpu_reset=0 from the cycle after the last mem_we.
//     ERR: error=1, busy=0, cpu_reset stays 1.
//   mem_addr never wraps: N<=DEPTH guarantees the maximum address is DEPTH-1.
//   reset_n low mid-session: immediate return to reset values.
//     Partially written imem contents are not cleared; the loader does not own imem.
//   mem_we is 0 in every cycle without a completed payload word.
// CONFIGURATION
//   IMEM_LOADER_CHECKSUM_EN defined:
//     After N payload words, one more LE word is received in state CHK.
//     It must equal the XOR of all N payload words: equal -> DONE, unequal -> ERR.
//     Payload writes are already committed when the check fails.
//     For N==0, HDR -> CHK and the expected checksum is 0.
//   IMEM_LOADER_CHECKSUM_EN undefined:
//     No CHK state. DATA -> DONE after the Nth word. No trailing word is consumed.
// TESTING
//   1. reset_n=0 mid-clock -> all outputs at reset values, with no clk edge needed.
//   2. start; bytes 03 00 00 00, b3 03 53 00, 33 85 84 40, 93 06 16 00 ->
//      mem_we pulses: addr0=0x005303b3, addr1=0x40848533, addr2=0x00160693;
//      then done=1, cpu_reset=0, words_loaded=3.
//   3. start; header 0x21 (33) -> error=1, no mem_we, cpu_reset=1, in_ready=0.
//   4. Scenario 2 with in_valid low 1-5 random cycles between bytes ->
//      identical writes and final state; start pulses mid-stream are ignored.
//   5. reset_n low after 2 words of scenario 2 -> reset values.
//      Then start + full frame -> writes restart at addr 0 and done=1.
//   6. With CHECKSUM_EN: scenario 2 + trailer 0x00160693^0x40848533^0x005303b3
//      -> done=1. Same frame with trailer 0x00000000 -> error=1, cpu_reset=1.

Source files
------------

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Byte-stream instruction memory loader. Receives a framed
//                byte stream (LE 32-bit header N, N LE payload words and an
//                optional LE checksum word), packs the bytes into 32-bit
//                words and writes them into instruction memory one word at
//                a time. The CPU core is held in reset until a load session
//                completes successfully.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH         instruction memory depth in words
//    ADDR_W        word address width, must equal $clog2(DEPTH)
//  Ports
//    clk           rising-edge clock
//    reset_n       asynchronous active-low reset
//    start         one-cycle pulse, begins a load session (ignored mid-session)
//    in_valid      byte-stream valid
//    in_data       byte-stream data
//    in_ready      byte accepted when in_valid & in_ready
//    mem_we        imem write enable, one-cycle pulse per payload word
//    mem_addr      imem word address
//    mem_wdata     imem write data
//    cpu_reset     active-high reset to the CPU core
//    busy          load session in progress
//    done          sticky, last session completed successfully
//    error         sticky, last session aborted
//    words_loaded  payload words written in the current/last session
//  Configuration
//    IMEM_LOADER_CHECKSUM_EN  when defined, a trailing checksum word equal to
//                             the XOR of all payload words is required.
// ============================================================================
module imem_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [31:0]   C_DEPTH_WORD = 32'(DEPTH);
  localparam logic [ADDR_W:0] C_ONE      = (ADDR_W+1)'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         shift_q, shift_d;       // bytes 0..2 of the word in flight
  logic [ADDR_W:0]     count_q, count_d;       // latched header word count N
  logic [ADDR_W:0]     words_loaded_q, words_loaded_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]         csum_q, csum_d;         // running XOR of payload words
`endif

  logic                w_accept;
  logic                w_word_done;
  logic [31:0]         w_word;
  logic                w_last_word;

  // in_ready depends only on the state register, so it falls to 0 at once on
  // an asynchronous reset and at the edge that completes the last field.
  assign in_ready = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);

  assign w_accept    = in_valid & in_ready;
  assign w_word_done = w_accept && (byte_cnt_q == 2'd3);
  // The fourth byte is consumed straight from the input; it is never stored.
  assign w_word      = {in_data, shift_q};
  assign w_last_word = ((words_loaded_q + C_ONE) == count_q);

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    shift_d        = shift_q;
    count_d        = count_q;
    words_loaded_d = words_loaded_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    cpu_reset_d    = cpu_reset_q;
    busy_d         = busy_q;
    done_d         = done_q;
    error_d        = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d         = csum_q;
`endif

    // Byte packing, common to every field of the frame.
    if (w_accept) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      case (byte_cnt_q)
        2'd0:    shift_d[7:0]   = in_data;
        2'd1:    shift_d[15:8]  = in_data;
        2'd2:    shift_d[23:16] = in_data;
        default: shift_d        = shift_q;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d        = S_HDR;
          done_d         = 1'b0;
          error_d        = 1'b0;
          words_loaded_d = '0;
          byte_cnt_d     = 2'd0;
          cpu_reset_d    = 1'b1;
          busy_d         = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d         = '0;
`endif
        end
      end

      S_HDR: begin
        if (w_word_done) begin
          if (w_word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            // Empty payload still carries a trailer; XOR of nothing is 0.
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else if (w_word > C_DEPTH_WORD) begin
            state_d = S_ERR;
          end else begin
            count_d = w_word[ADDR_W:0];
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (w_word_done) begin
          // Registered write: the word appears on the imem port the cycle
          // after its fourth byte. N <= DEPTH keeps the address in range.
          mem_we_d       = 1'b1;
          mem_addr_d     = words_loaded_q[ADDR_W-1:0];
          mem_wdata_d    = w_word;
          words_loaded_d = words_loaded_q + C_ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d         = csum_q ^ w_word;
`endif
          if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_word_done) begin
          // Payload writes are already committed; a mismatch only flags it.
          if (w_word == csum_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
          end
        end
      end
`endif

      S_DONE: begin
        // Status flags register while in DONE, so they show up the cycle
        // after the final write pulse rather than together with it.
        done_d      = 1'b1;
        busy_d      = 1'b0;
        cpu_reset_d = 1'b0;
        if (start) begin
          state_d        = S_HDR;
          done_d         = 1'b0;
          error_d        = 1'b0;
          words_loaded_d = '0;
          byte_cnt_d     = 2'd0;
          cpu_reset_d    = 1'b1;
          busy_d         = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d         = '0;
`endif
        end
      end

      S_ERR: begin
        // The CPU stays in reset after an aborted load.
        error_d = 1'b1;
        busy_d  = 1'b0;
        if (start) begin
          state_d        = S_HDR;
          done_d         = 1'b0;
          error_d        = 1'b0;
          words_loaded_d = '0;
          byte_cnt_d     = 2'd0;
          cpu_reset_d    = 1'b1;
          busy_d         = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d         = '0;
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      byte_cnt_q     <= 2'd0;
      shift_q        <= '0;
      count_q        <= '0;
      words_loaded_q <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      cpu_reset_q    <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      shift_q        <= shift_d;
      count_q        <= count_d;
      words_loaded_q <= words_loaded_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      cpu_reset_q    <= cpu_reset_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q         <= csum_d;
`endif
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_reset    = cpu_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader. Expected imem writes
//                are queued as frames are driven and compared whenever the
//                loader pulses mem_we.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          we_count = 0;
  int          last_we_cyc = 0;
  logic [36:0] exp_q[$];          // {addr[4:0], data[31:0]}
  logic [31:0] words [0:DEPTH-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard consumer: every write pulse must match the oldest queued word.
  always @(negedge clk) begin
    if (reset_n && mem_we) begin
      logic [36:0] e;
      we_count++;
      last_we_cyc = cyc;
      chk("we_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      if (exp_q.size() == 0) begin
        chk("we_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("we_addr", {27'd0, mem_addr}, {27'd0, e[36:32]});
        chk("we_data", mem_wdata, e[31:0]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap, input bit pulses);
    int gap;
    bit ok;
    gap = (maxgap > 0) ? $urandom_range(maxgap, 1) : 0;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      start = pulses ? 1'($urandom_range(1, 0)) : 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap, input bit pulses);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], maxgap, pulses);
  endtask

  // Drives a whole session: start pulse, header, n_data payload words from
  // words[], and a trailer when the checksum build expects one.
  task automatic run_frame(input logic [31:0] hdr, input int n_data, input int maxgap,
                           input bit pulses, input bit bad_trailer);
    logic [31:0] csum;
    csum = 32'd0;
    pulse_start();
    send_word(hdr, maxgap, pulses);
    for (int i = 0; i < n_data; i++) begin
      exp_q.push_back({5'(i), words[i]});
      csum = csum ^ words[i];
      send_word(words[i], maxgap, pulses);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (hdr <= 32'(DEPTH)) send_word(bad_trailer ? 32'h0 : csum, maxgap, pulses);
`else
    if (bad_trailer) csum = 32'd0;
`endif
  endtask

  task automatic expect_end(input string pfx, input bit exp_ok, input int exp_wl,
                            input bit check_lat);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (done || error) begin
        seen = 1'b1;
        break;
      end
    end
    chk({pfx, "_ended"},    {31'd0, seen},      32'd1);
    chk({pfx, "_done"},     {31'd0, done},      {31'd0, exp_ok});
    chk({pfx, "_error"},    {31'd0, error},     {31'd0, !exp_ok});
    chk({pfx, "_cpu_rst"},  {31'd0, cpu_reset}, {31'd0, !exp_ok});
    chk({pfx, "_busy"},     {31'd0, busy},      32'd0);
    chk({pfx, "_in_ready"}, {31'd0, in_ready},  32'd0);
    chk({pfx, "_wl"},       {26'd0, words_loaded}, 32'(exp_wl));
    chk({pfx, "_sb_empty"}, 32'(exp_q.size()),  32'd0);
    if (check_lat) chk({pfx, "_done_lat"}, 32'(cyc - last_we_cyc), 32'd1);
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_in_ready"}, {31'd0, in_ready},  32'd0);
    chk({pfx, "_mem_we"},   {31'd0, mem_we},    32'd0);
    chk({pfx, "_mem_addr"}, {27'd0, mem_addr},  32'd0);
    chk({pfx, "_wdata"},    mem_wdata,          32'd0);
    chk({pfx, "_cpu_rst"},  {31'd0, cpu_reset}, 32'd1);
    chk({pfx, "_busy"},     {31'd0, busy},      32'd0);
    chk({pfx, "_done"},     {31'd0, done},      32'd0);
    chk({pfx, "_error"},    {31'd0, error},     32'd0);
    chk({pfx, "_wl"},       {26'd0, words_loaded}, 32'd0);
  endtask

  // Asserts reset between clock edges and checks outputs before any edge.
  task automatic mid_clock_reset(input string pfx);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check_reset_vals(pfx);
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic load_scenario2();
    words[0] = 32'h005303b3;
    words[1] = 32'h40848533;
    words[2] = 32'h00160693;
  endtask

  initial begin
    bit ck_lat;
`ifdef IMEM_LOADER_CHECKSUM_EN
    ck_lat = 1'b0;
`else
    ck_lat = 1'b1;
`endif
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #12;
    check_reset_vals("por");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic three-word program, no gaps.
    load_scenario2();
    run_frame(32'd3, 3, 0, 1'b0, 1'b0);
    expect_end("s2", 1'b1, 3, ck_lat);

    // Asynchronous reset from a completed, non-trivial state.
    mid_clock_reset("rst_async");

    // Oversized header aborts without writing.
    we_count = 0;
    run_frame(32'd33, 0, 0, 1'b0, 1'b0);
    expect_end("hdr33", 1'b0, 0, 1'b0);
    chk("hdr33_no_we", 32'(we_count), 32'd0);

    // Random gaps with ignored mid-stream start pulses.
    run_frame(32'd3, 3, 5, 1'b1, 1'b0);
    expect_end("gaps", 1'b1, 3, ck_lat);

    // Reset after two words, then a clean reload from address 0.
    pulse_start();
    send_word(32'd3, 0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({5'(i), words[i]});
      send_word(words[i], 0, 1'b0);
    end
    repeat (2) @(negedge clk);
    chk("part_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("part_wl", {26'd0, words_loaded}, 32'd2);
    mid_clock_reset("rst_mid");
    run_frame(32'd3, 3, 2, 1'b0, 1'b0);
    expect_end("reload", 1'b1, 3, ck_lat);

    // Empty frame.
    run_frame(32'd0, 0, 0, 1'b0, 1'b0);
    expect_end("n0", 1'b1, 0, 1'b0);

    // Full-depth frame reaches the last address.
    for (int i = 0; i < DEPTH; i++) words[i] = $urandom();
    run_frame(32'(DEPTH), DEPTH, 0, 1'b0, 1'b0);
    expect_end("n32", 1'b1, DEPTH, ck_lat);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong trailer: payload still written, session flagged as error.
    load_scenario2();
    run_frame(32'd3, 3, 0, 1'b0, 1'b1);
    expect_end("ck_bad", 1'b0, 3, 1'b0);
    run_frame(32'd3, 3, 0, 1'b0, 1'b0);
    expect_end("ck_good", 1'b1, 3, 1'b0);
`endif

    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
